// File: rtl/pcie_vc_arbiter.sv
// ---------------------------------------------------------------------------
// pcie_vc_arbiter
//
// Drains the two transaction-layer virtual-channel FIFOs (VC0, VC1) into two
// destination FIFOs (D0, D1). Each cycle at most one non-empty VC is popped,
// chosen by weighted round-robin. The popped word arrives on the VC data bus
// one cycle after the pop. It is then registered onto data_out_o together
// with a push strobe for the destination selected by bit ROUTE_BIT of the
// word. Pop-to-push latency is 2 cycles.
//
// Optional build macro:
//   VC_STRICT_PRIORITY_EN - VC0 always wins when non-empty. The weights, the
//                           grant pointer and the grant counter are not built.
//
// Ports:
//   clk_i              clock
//   reset_i            synchronous active-high reset
//   state_i[3:0]       one-hot control state (0001 reset, 0010 init,
//                      0100 idle, 1000 active)
//   vc0_data_i         VC0 FIFO data_out, valid the cycle after a pop
//   vc1_data_i         VC1 FIFO data_out, valid the cycle after a pop
//   vc0_empty_i        VC0 FIFO empty
//   vc1_empty_i        VC1 FIFO empty
//   d0_almost_full_i   D0 FIFO almost_full
//   d1_almost_full_i   D1 FIFO almost_full
//   vc0_pop_o          registered pop strobe to VC0
//   vc1_pop_o          registered pop strobe to VC1
//   data_out_o         word pushed to the destination FIFOs
//   d0_push_o          push strobe to D0
//   d1_push_o          push strobe to D1
//   idle_o             pipeline empty and no pop issued this cycle
// ---------------------------------------------------------------------------
module pcie_vc_arbiter #(
  parameter int DATA_W     = 12,
  parameter int ROUTE_BIT  = 8,
  parameter int VC0_WEIGHT = 2,
  parameter int VC1_WEIGHT = 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [3:0]        state_i,
  input  logic [DATA_W-1:0] vc0_data_i,
  input  logic [DATA_W-1:0] vc1_data_i,
  input  logic              vc0_empty_i,
  input  logic              vc1_empty_i,
  input  logic              d0_almost_full_i,
  input  logic              d1_almost_full_i,
  output logic              vc0_pop_o,
  output logic              vc1_pop_o,
  output logic [DATA_W-1:0] data_out_o,
  output logic              d0_push_o,
  output logic              d1_push_o,
  output logic              idle_o
);

  localparam logic [3:0] ST_RESET  = 4'b0001;
  localparam logic [3:0] ST_ACTIVE = 4'b1000;

  // The control-state reset code clears the block exactly like reset_i.
  logic clear;
  assign clear = reset_i | (state_i == ST_RESET);

  // The destination is unknown until the word is read, so either
  // almost_full blocks every new pop.
  logic pop_ok;
  logic cand0;
  logic cand1;
  logic any_gnt;
  logic gnt_vc;  // 0 = VC0, 1 = VC1

  assign pop_ok  = (state_i == ST_ACTIVE) & ~d0_almost_full_i & ~d1_almost_full_i;
  assign cand0   = ~vc0_empty_i;
  assign cand1   = ~vc1_empty_i;
  assign any_gnt = pop_ok & (cand0 | cand1);

`ifdef VC_STRICT_PRIORITY_EN
  assign gnt_vc = ~cand0;
`else
  localparam logic [2:0] W0 = 3'(VC0_WEIGHT);
  localparam logic [2:0] W1 = 3'(VC1_WEIGHT);

  logic       ptr_q,  ptr_d;   // VC preferred when both are candidates
  logic       last_q, last_d;  // VC granted most recently
  logic [2:0] cnt_q,  cnt_d;   // consecutive grants to last_q
  logic [2:0] gnt_wt;

  always_comb begin
    gnt_vc = cand1 & (~cand0 | ptr_q);
    gnt_wt = gnt_vc ? W1 : W0;
    ptr_d  = ptr_q;
    last_d = last_q;
    cnt_d  = cnt_q;
    if (any_gnt) begin
      // A lone candidate keeps winning; its count saturates at its weight.
      if (gnt_vc == last_q) begin
        cnt_d = (cnt_q >= gnt_wt) ? gnt_wt : cnt_q + 3'd1;
      end else begin
        cnt_d = 3'd1;
      end
      last_d = gnt_vc;
      ptr_d  = (cnt_d >= gnt_wt) ? ~gnt_vc : gnt_vc;
    end
  end

  always_ff @(posedge clk_i) begin
    if (clear) begin
      ptr_q  <= 1'b0;
      last_q <= 1'b0;
      cnt_q  <= 3'd0;
    end else begin
      ptr_q  <= ptr_d;
      last_q <= last_d;
      cnt_q  <= cnt_d;
    end
  end
`endif

  // Pop strobes and the two pipeline stages.
  logic              vc0_pop_q, vc0_pop_d;
  logic              vc1_pop_q, vc1_pop_d;
  logic              valid_q;
  logic              src_q;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              d0_push_q, d0_push_d;
  logic              d1_push_q, d1_push_d;
  logic [DATA_W-1:0] sel_word;

  // The VC data bus carries the popped word during the cycle valid_q is set.
  assign sel_word = src_q ? vc1_data_i : vc0_data_i;

  always_comb begin
    vc0_pop_d  = any_gnt & ~gnt_vc;
    vc1_pop_d  = any_gnt & gnt_vc;
    d0_push_d  = valid_q & ~sel_word[ROUTE_BIT];
    d1_push_d  = valid_q & sel_word[ROUTE_BIT];
    data_out_d = valid_q ? sel_word : data_out_q;
  end

  always_ff @(posedge clk_i) begin
    if (clear) begin
      vc0_pop_q  <= 1'b0;
      vc1_pop_q  <= 1'b0;
      valid_q    <= 1'b0;
      src_q      <= 1'b0;
      data_out_q <= '0;
      d0_push_q  <= 1'b0;
      d1_push_q  <= 1'b0;
    end else begin
      vc0_pop_q  <= vc0_pop_d;
      vc1_pop_q  <= vc1_pop_d;
      valid_q    <= vc0_pop_q | vc1_pop_q;
      src_q      <= vc1_pop_q;
      data_out_q <= data_out_d;
      d0_push_q  <= d0_push_d;
      d1_push_q  <= d1_push_d;
    end
  end

  assign vc0_pop_o  = vc0_pop_q;
  assign vc1_pop_o  = vc1_pop_q;
  assign data_out_o = data_out_q;
  assign d0_push_o  = d0_push_q;
  assign d1_push_o  = d1_push_q;
  assign idle_o     = ~valid_q & ~vc0_pop_q & ~vc1_pop_q;

endmodule

// File: tb/tb_pcie_vc_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pcie_vc_arbiter
//
// Directed bench for pcie_vc_arbiter (DATA_W=12, ROUTE_BIT=8, weights 2/1).
// Inputs are driven on the falling edge. Each record is consumed by the
// following rising edge, and outputs are compared at the next falling edge.
// The expected values therefore describe the registers after the edge that
// consumed the record. The VC data fields carry the word that the FIFO
// presents in that cycle, which is the cycle after the matching pop.
// ---------------------------------------------------------------------------
module tb_pcie_vc_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  state;
  logic [11:0] vc0_data;
  logic [11:0] vc1_data;
  logic        vc0_empty;
  logic        vc1_empty;
  logic        d0_af;
  logic        d1_af;
  logic        vc0_pop;
  logic        vc1_pop;
  logic [11:0] data_out;
  logic        d0_push;
  logic        d1_push;
  logic        idle;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pcie_vc_arbiter #(
    .DATA_W(12), .ROUTE_BIT(8), .VC0_WEIGHT(2), .VC1_WEIGHT(1)
  ) dut (
    .clk_i(clk),
    .reset_i(reset),
    .state_i(state),
    .vc0_data_i(vc0_data),
    .vc1_data_i(vc1_data),
    .vc0_empty_i(vc0_empty),
    .vc1_empty_i(vc1_empty),
    .d0_almost_full_i(d0_af),
    .d1_almost_full_i(d1_af),
    .vc0_pop_o(vc0_pop),
    .vc1_pop_o(vc1_pop),
    .data_out_o(data_out),
    .d0_push_o(d0_push),
    .d1_push_o(d1_push),
    .idle_o(idle)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  st;
    logic        e0;
    logic        e1;
    logic        af0;
    logic        af1;
    logic [11:0] dat0;
    logic [11:0] dat1;
    logic        x_pop0;
    logic        x_pop1;
    logic        x_push0;
    logic        x_push1;
    logic [11:0] x_dout;
    logic        x_idle;
  } vec_t;

  function automatic vec_t mk(
    input logic rst, input logic [3:0] st, input logic e0, input logic e1,
    input logic af0, input logic af1, input logic [11:0] dat0, input logic [11:0] dat1,
    input logic x_pop0, input logic x_pop1, input logic x_push0, input logic x_push1,
    input logic [11:0] x_dout, input logic x_idle);
    vec_t v;
    v.rst = rst; v.st = st; v.e0 = e0; v.e1 = e1; v.af0 = af0; v.af1 = af1;
    v.dat0 = dat0; v.dat1 = dat1;
    v.x_pop0 = x_pop0; v.x_pop1 = x_pop1; v.x_push0 = x_push0; v.x_push1 = x_push1;
    v.x_dout = x_dout; v.x_idle = x_idle;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    reset     = v.rst;
    state     = v.st;
    vc0_empty = v.e0;
    vc1_empty = v.e1;
    d0_af     = v.af0;
    d1_af     = v.af1;
    vc0_data  = v.dat0;
    vc1_data  = v.dat1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, " vc0_pop"},  {15'd0, vc0_pop},  {15'd0, v.x_pop0});
    chk({tag, " vc1_pop"},  {15'd0, vc1_pop},  {15'd0, v.x_pop1});
    chk({tag, " d0_push"},  {15'd0, d0_push},  {15'd0, v.x_push0});
    chk({tag, " d1_push"},  {15'd0, d1_push},  {15'd0, v.x_push1});
    chk({tag, " data_out"}, {4'd0, data_out},  {4'd0, v.x_dout});
    chk({tag, " idle"},     {15'd0, idle},     {15'd0, v.x_idle});
  endtask

  localparam logic [3:0] S_RST = 4'b0001;
  localparam logic [3:0] S_IDL = 4'b0100;
  localparam logic [3:0] S_ACT = 4'b1000;
  localparam logic [3:0] S_BAD = 4'b0110;

  vec_t vecs[$];

  initial begin
    reset = 1'b1; state = S_RST; vc0_data = '0; vc1_data = '0;
    vc0_empty = 1'b1; vc1_empty = 1'b1; d0_af = 1'b0; d1_af = 1'b0;
    @(negedge clk);
    @(negedge clk);

`ifndef VC_STRICT_PRIORITY_EN
    //            rst st     e0 e1 af0 af1 dat0     dat1      p0 p1 q0 q1 dout     idle
    vecs.push_back(mk(1, S_RST, 1, 1, 0, 0, 12'h000, 12'h000,  0, 0, 0, 0, 12'h000, 1));
    vecs.push_back(mk(0, S_ACT, 0, 1, 0, 0, 12'h000, 12'h000,  1, 0, 0, 0, 12'h000, 0));
    vecs.push_back(mk(0, S_ACT, 0, 1, 0, 0, 12'h000, 12'h000,  1, 0, 0, 0, 12'h000, 0));
    // Both VCs busy: grants VC1, VC0, VC0, VC1 continue the 2/1 pattern.
    vecs.push_back(mk(0, S_ACT, 0, 0, 0, 0, 12'h123, 12'h000,  0, 1, 0, 1, 12'h123, 0));
    vecs.push_back(mk(0, S_ACT, 0, 0, 0, 0, 12'h0AB, 12'h000,  1, 0, 1, 0, 12'h0AB, 0));
    vecs.push_back(mk(0, S_ACT, 0, 0, 0, 0, 12'h000, 12'h1FF,  1, 0, 0, 1, 12'h1FF, 0));
    vecs.push_back(mk(0, S_ACT, 0, 0, 0, 0, 12'h055, 12'h000,  0, 1, 1, 0, 12'h055, 0));
    // d0 almost_full with two words in flight: both still pushed, no new pops.
    vecs.push_back(mk(0, S_ACT, 0, 0, 1, 0, 12'h300, 12'h000,  0, 0, 0, 1, 12'h300, 0));
    vecs.push_back(mk(0, S_ACT, 0, 0, 1, 0, 12'h000, 12'h004,  0, 0, 1, 0, 12'h004, 1));
    vecs.push_back(mk(0, S_ACT, 0, 0, 1, 0, 12'h000, 12'h000,  0, 0, 0, 0, 12'h004, 1));
    vecs.push_back(mk(0, S_ACT, 0, 0, 0, 0, 12'h000, 12'h000,  1, 0, 0, 0, 12'h004, 0));
    // Idle state mid-stream: pops stop, the in-flight word completes.
    vecs.push_back(mk(0, S_IDL, 0, 0, 0, 0, 12'h000, 12'h000,  0, 0, 0, 0, 12'h004, 0));
    vecs.push_back(mk(0, S_IDL, 0, 0, 0, 0, 12'h0F0, 12'h000,  0, 0, 1, 0, 12'h0F0, 1));
    vecs.push_back(mk(0, S_BAD, 0, 0, 0, 0, 12'h000, 12'h000,  0, 0, 0, 0, 12'h0F0, 1));
    // Lone VC1 keeps winning despite its weight of 1.
    vecs.push_back(mk(0, S_ACT, 1, 0, 0, 0, 12'h000, 12'h000,  0, 1, 0, 0, 12'h0F0, 0));
    vecs.push_back(mk(0, S_ACT, 1, 0, 0, 0, 12'h000, 12'h000,  0, 1, 0, 0, 12'h0F0, 0));
    vecs.push_back(mk(0, S_ACT, 1, 1, 0, 0, 12'h000, 12'h1AA,  0, 0, 0, 1, 12'h1AA, 0));
    // Reset with a word in flight: it is dropped and data_out clears.
    vecs.push_back(mk(1, S_ACT, 1, 1, 0, 0, 12'h000, 12'h0CC,  0, 0, 0, 0, 12'h000, 1));
    vecs.push_back(mk(0, S_ACT, 0, 0, 0, 0, 12'h000, 12'h000,  1, 0, 0, 0, 12'h000, 0));
    // Control state 0001 acts as reset.
    vecs.push_back(mk(0, S_RST, 0, 0, 0, 0, 12'h000, 12'h000,  0, 0, 0, 0, 12'h000, 1));
    vecs.push_back(mk(0, S_ACT, 0, 0, 0, 0, 12'h000, 12'h000,  1, 0, 0, 0, 12'h000, 0));
    vecs.push_back(mk(0, S_ACT, 0, 0, 0, 1, 12'h000, 12'h000,  0, 0, 0, 0, 12'h000, 0));
    vecs.push_back(mk(0, S_ACT, 0, 0, 0, 1, 12'h077, 12'h000,  0, 0, 1, 0, 12'h077, 1));

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("row%0d", i));
`else
    // Strict priority: VC0 wins for as long as it is non-empty.
    run_vec(mk(1, S_RST, 1, 1, 0, 0, 12'h000, 12'h000,  0, 0, 0, 0, 12'h000, 1), "sp0");
    run_vec(mk(0, S_ACT, 0, 0, 0, 0, 12'h000, 12'h000,  1, 0, 0, 0, 12'h000, 0), "sp1");
    run_vec(mk(0, S_ACT, 0, 0, 0, 0, 12'h000, 12'h000,  1, 0, 0, 0, 12'h000, 0), "sp2");
    run_vec(mk(0, S_ACT, 0, 0, 0, 0, 12'h011, 12'h000,  1, 0, 1, 0, 12'h011, 0), "sp3");
    run_vec(mk(0, S_ACT, 0, 0, 0, 0, 12'h122, 12'h000,  1, 0, 0, 1, 12'h122, 0), "sp4");
    run_vec(mk(0, S_ACT, 0, 0, 0, 0, 12'h033, 12'h000,  1, 0, 1, 0, 12'h033, 0), "sp5");
    run_vec(mk(0, S_ACT, 1, 0, 0, 0, 12'h044, 12'h000,  0, 1, 1, 0, 12'h044, 0), "sp6");
`endif

    // Single VC: VC1 holds 0x100, 0x005, 0x1FF; pushes land 2 cycles after pops.
    run_vec(mk(1, S_ACT, 1, 1, 0, 0, 12'h000, 12'h000,  0, 0, 0, 0, 12'h000, 1), "sv0");
    run_vec(mk(0, S_ACT, 1, 0, 0, 0, 12'h000, 12'h000,  0, 1, 0, 0, 12'h000, 0), "sv1");
    run_vec(mk(0, S_ACT, 1, 0, 0, 0, 12'h000, 12'h000,  0, 1, 0, 0, 12'h000, 0), "sv2");
    run_vec(mk(0, S_ACT, 1, 0, 0, 0, 12'h000, 12'h100,  0, 1, 0, 1, 12'h100, 0), "sv3");
    run_vec(mk(0, S_ACT, 1, 1, 0, 0, 12'h000, 12'h005,  0, 0, 1, 0, 12'h005, 0), "sv4");
    run_vec(mk(0, S_ACT, 1, 1, 0, 0, 12'h000, 12'h1FF,  0, 0, 0, 1, 12'h1FF, 1), "sv5");
    run_vec(mk(0, S_ACT, 1, 1, 0, 0, 12'h000, 12'h000,  0, 0, 0, 0, 12'h1FF, 1), "sv6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pcie_vc_arbiter.md
Name: pcie_vc_arbiter

Overview:
- Downstream consumer of the two virtual-channel FIFOs (VC0, VC1) in the transaction layer.
- Each cycle it selects at most one non-empty VC FIFO using weighted round-robin and drives that FIFO's pop.
- It captures the popped 12-bit word and pushes it into one of two destination FIFOs (D0, D1), chosen by a routing bit in the word.
- Honours destination almost_full backpressure and the shared one-hot control state used by the FIFOs.

Parameters:
- DATA_W, 12, word width; must match the FIFO width.
- ROUTE_BIT, 8, index of the data bit that selects the destination (0 -> D0, 1 -> D1).
- VC0_WEIGHT, 2, maximum consecutive VC0 grants before VC1 is offered (range 1..7).
- VC1_WEIGHT, 1, maximum consecutive VC1 grants before VC0 is offered (range 1..7).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- state  input  4  one-hot control state: 0001 reset, 0010 init, 0100 idle, 1000 active.
- vc0_data  input  DATA_W  VC0 FIFO data_out; valid the cycle after a pop.
- vc1_data  input  DATA_W  VC1 FIFO data_out; valid the cycle after a pop.
- vc0_empty  input  1  VC0 FIFO holds no words.
- vc1_empty  input  1  VC1 FIFO holds no words.
- d0_almost_full  input  1  D0 FIFO almost_full.
- d1_almost_full  input  1  D1 FIFO almost_full.
- vc0_pop  output  1  pop strobe to VC0.
- vc1_pop  output  1  pop strobe to VC1.
- data_out  output  DATA_W  word pushed to the destination FIFOs.
- d0_push  output  1  push strobe to D0.
- d1_push  output  1  push strobe to D1.
- idle  output  1  high when the pipeline is empty and no pop was issued this cycle.

Behaviour:
- Reset: reset=1 or state==0001 clears all outputs and internal registers to 0 on the next edge.
  - Grant pointer resets to VC0; grant counter resets to 0.
  - Reset mid-operation discards in-flight words; no push occurs for them.
- State gating:
  - Pops are issued only when state==1000.
  - In 0010 and 0100, no new pops are issued, but words already in the pipeline still complete their push.
  - Any other state value behaves as 0100.
- Pop eligibility: pop allowed only when d0_almost_full==0 and d1_almost_full==0 (conservative, because the destination is unknown before the pop).
- Arbiter (registered pop outputs, at most one pop high per cycle):
  - Candidates: VCs with empty==0.
  - No candidates, or pop not allowed: both pops 0; pointer and counter hold.
  - One candidate: grant it.
  - Two candidates: grant the pointer VC.
  - Counter: on a grant to the same VC as last time, counter+1; on a grant to a different VC, counter=1.
  - When counter reaches that VC's weight, the pointer moves to the other VC. A lone candidate may keep being granted; its counter saturates at its weight.
- Pipeline, for a pop at cycle N:
  - Stage 1 (edge ending N): registers valid_q=1 and src_q=granted VC.
  - Cycle N+1: selects vc0_data or vc1_data by src_q and routes by data[ROUTE_BIT].
  - Edge ending N+1: registers data_out and exactly one of d0_push/d1_push.
  - Push is therefore visible in cycle N+2. Pop-to-push latency is 2 cycles.
  - Back-to-back pops yield back-to-back pushes.
- Outputs when no push: data_out holds its last value; d0_push=d1_push=0.
- Backpressure slack: up to 2 words may be in flight when almost_full rises. Destination umbral_AF must leave at least 2 free entries; this is not checked by this block.
- Simultaneous events:
  - vc empty rising in the same cycle as the arbitration decision: that VC is not granted.
  - almost_full rising during in-flight words: the in-flight words are still pushed.
- idle = ~valid_q & ~vc0_pop & ~vc1_pop (registered view).

Optional Feature:
- Macro: VC_STRICT_PRIORITY_EN.
- Defined: weights ignored; VC0 always wins when non-empty; VC1 is granted only when VC0 is empty. Pointer and counter logic are omitted.
- Undefined: weighted round-robin as described above.

Test Plan:
- Reset: apply reset=1 with pops pending -> next cycle all outputs 0, idle=1; a word popped one cycle before reset is never pushed.
- Single VC: VC1 holds 3 words (0x100, 0x005, 0x1FF), VC0 empty, state=1000 -> vc1_pop high 3 consecutive cycles; pushes 2 cycles later: D1 0x100, D0 0x005, D1 0x1FF.
- Weighted RR: both VCs continuously non-empty, weights 2/1 -> grant sequence VC0,VC0,VC1,VC0,VC0,VC1…
- Backpressure: d0_almost_full rises in cycle N with 2 pops in flight -> no pop from N onward; exactly 2 pushes complete; pops resume the cycle after almost_full falls.
- State gating: switch state to 0100 mid-stream -> pops stop next cycle; in-flight words pushed; no further pushes.
- VC_STRICT_PRIORITY_EN defined, both VCs non-empty for 5 cycles -> only vc0_pop asserted; vc1_pop only after vc0_empty=1.
